// File: rtl/wb_rr_arbiter_n.sv
// N-master to 1-slave Wishbone pipelined arbiter.
// Ownership is granted for a whole cycle and held until the owner drops cyc.
// An outstanding-transfer counter limits how far the owner may run ahead of
// the slave. It also makes sure that ack/err responses reach only the master
// that issued them.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no owner; slave cyc/stb low, every master stalled
// ST_OWNED | grant_q owns the slave; its cyc/stb/data drive the slave port
module wb_rr_arbiter_n #(
  parameter int NM               = 4,
  parameter int AW               = 32,
  parameter int DW               = 32,
  parameter int RR_MODE          = 1,
  parameter int MAX_OUTSTANDING  = 4,
  parameter int OPT_ZERO_ON_IDLE = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NM-1:0]        m_cyc,
  input  logic [NM-1:0]        m_stb,
  input  logic [NM-1:0]        m_we,
  input  logic [NM*AW-1:0]     m_addr,
  input  logic [NM*DW-1:0]     m_data,
  input  logic [NM*DW/8-1:0]   m_sel,
  output logic [NM-1:0]        m_stall,
  output logic [NM-1:0]        m_ack,
  output logic [NM-1:0]        m_err,
  output logic                 o_cyc,
  output logic                 o_stb,
  output logic                 o_we,
  output logic [AW-1:0]        o_addr,
  output logic [DW-1:0]        o_data,
  output logic [DW/8-1:0]      o_sel,
  input  logic                 i_stall,
  input  logic                 i_ack,
  input  logic                 i_err
);

  localparam int SW = DW / 8;
  localparam int GW = $clog2(NM);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {ST_IDLE, ST_OWNED} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [GW-1:0] winner;
  logic [GW-1:0] mux_idx;
  logic          rr_found;
  int            rr_idx;
  logic          owned;
  logic          owner_cyc;
  logic          full;
  logic          accept;
  logic          resp_ok;

  assign owned     = (state_q == ST_OWNED);
  assign owner_cyc = owned & m_cyc[grant_q];
  assign full      = (outst_q == OW'(MAX_OUTSTANDING));
  assign accept    = o_stb & ~i_stall;
  // A response is only routed while the owner still holds cyc and something
  // is actually in flight; anything else is a stray or an aborted burst.
  assign resp_ok   = owner_cyc & (outst_q != '0);
  assign mux_idx   = owned ? grant_q : '0;

  // Pick the next owner: lowest index (fixed) or first requester after last owner (RR).
  always_comb begin
    winner   = '0;
    rr_found = 1'b0;
    rr_idx   = 0;
    if (RR_MODE == 0) begin
      for (int i = NM - 1; i >= 0; i--) begin
        if (m_cyc[i]) winner = GW'(i);
      end
    end else begin
      for (int k = 1; k <= NM; k++) begin
        rr_idx = (int'(last_q) + k) % NM;
        if (!rr_found && m_cyc[rr_idx]) begin
          winner   = GW'(rr_idx);
          rr_found = 1'b1;
        end
      end
    end
  end

  // Next-state logic for ownership and the outstanding-transfer counter.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    outst_d = outst_q;
    case (state_q)
      ST_IDLE: begin
        outst_d = '0;
        if (|m_cyc) begin
          state_d = ST_OWNED;
          grant_d = winner;
        end
      end
      ST_OWNED: begin
        if (!m_cyc[grant_q]) begin
          state_d = ST_IDLE;
          last_d  = grant_q;
          outst_d = '0;
        end else if (resp_ok && i_err) begin
          // An error ends the burst: remaining acks are no longer expected.
          outst_d = accept ? OW'(1) : '0;
        end else if (resp_ok && i_ack && !accept) begin
          outst_d = outst_q - OW'(1);
        end else if (accept && !(resp_ok && i_ack)) begin
          outst_d = outst_q + OW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, grant and counter registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= GW'(NM - 1);
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      outst_q <= outst_d;
    end
  end

  // Slave-side mux and per-master stall/response routing.
  always_comb begin
    m_stall = '1;
    m_ack   = '0;
    m_err   = '0;
    o_cyc   = owner_cyc;
    o_stb   = owner_cyc & m_stb[grant_q] & ~full;
    o_we    = m_we[mux_idx];
    o_addr  = m_addr[int'(mux_idx) * AW +: AW];
    o_data  = m_data[int'(mux_idx) * DW +: DW];
    o_sel   = m_sel[int'(mux_idx) * SW +: SW];
    if (owned) begin
      m_stall[grant_q] = i_stall | full;
      m_ack[grant_q]   = i_ack & resp_ok;
      m_err[grant_q]   = i_err & resp_ok;
    end
    if ((OPT_ZERO_ON_IDLE != 0) && !o_stb) begin
      o_we   = 1'b0;
      o_addr = '0;
      o_data = '0;
      o_sel  = '0;
    end
  end

endmodule
